// File: rtl/rr_stream_arb_pkg.sv
// rr_stream_arb_pkg: shared state type and width helper for the round-robin stream arbiter
package rr_stream_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_stream_arb_if.sv
// rr_stream_arb_if: requester-side and datapath-side stream signals of the arbiter
interface rr_stream_arb_if
  import rr_stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int SRC_W = src_w(NUM_REQ);
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      out_vld;
  logic                      out_rdy;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  modport master (output req_vld, req_data, out_rdy, input req_rdy, out_vld, out_data, out_src);
  modport slave  (input req_vld, req_data, out_rdy, output req_rdy, out_vld, out_data, out_src);
endinterface

// File: rtl/rr_stream_arb_pick.sv
// rr_pick: rotating-priority picker, first set request strictly after ptr (wrapping)
module rr_pick
  import rr_stream_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int W = src_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);
  logic [2*N-1:0] w_dbl;
  int             w_pos;
  // the window ptr+1 .. ptr+N of the doubled vector covers every requester once
  always_comb begin
    w_dbl = {i_req, i_req} & ({(2*N){1'b1}} << (int'(i_ptr) + 1)) & ~({(2*N){1'b1}} << (int'(i_ptr) + N + 1));
    w_pos = 0;
    for (int k = 2*N-1; k >= 0; k--)
      if (w_dbl[k]) w_pos = k;
    o_idx = W'((w_pos >= N) ? w_pos - N : w_pos);
  end
  assign o_found = |i_req;
endmodule

// File: rtl/rr_stream_arb.sv
// rr_stream_arb: round-robin burst-locked arbiter feeding a registered, source-tagged output stage
module rr_stream_arb
  import rr_stream_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  rr_stream_arb_if.slave bus
);
  localparam int SRC_W = src_w(NUM_REQ);
  localparam int CNT_W = src_w(MAX_BURST);
  arb_state_e         r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_grant, r_ptr, w_win, r_out_src;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_vld;
  logic [DATA_W-1:0]  r_out_data, w_beat;
  logic               w_found, w_locked, w_load, w_gvld, w_xfer, w_release;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req  (bus.req_vld),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_idx  (w_win)
  );
  assign w_locked  = r_state == ARB_LOCKED;
  assign w_load    = !r_out_vld || bus.out_rdy;
  assign w_gvld    = bus.req_vld[r_grant];
  assign w_beat    = bus.req_data[r_grant*DATA_W +: DATA_W];
  assign w_xfer    = w_locked && w_load && w_gvld;
  // a stalled output stage holds the lock whatever the requester does
  assign w_release = w_locked && w_load && (!w_gvld || r_cnt == CNT_W'(MAX_BURST-1));
  assign bus.req_rdy  = (w_locked && w_load) ? NUM_REQ'(1) << r_grant : '0;
  assign bus.out_vld  = r_out_vld;
  assign bus.out_data = r_out_data;
  assign bus.out_src  = r_out_src;
  always_comb begin
    w_state_nxt = w_locked ? (w_release ? ARB_IDLE : ARB_LOCKED) : (w_found ? ARB_LOCKED : ARB_IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant    <= '0;
      r_ptr      <= SRC_W'(NUM_REQ-1);
      r_cnt      <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_src  <= '0;
    end else begin
      if (!w_locked && w_found) begin
        r_grant <= w_win;
        r_cnt   <= '0;
      end
      if (w_xfer) begin
        r_cnt      <= r_cnt + CNT_W'(1);
        r_out_data <= w_beat;
        r_out_src  <= r_grant;
      end
      if (w_release) r_ptr <= r_grant;
      r_out_vld <= w_xfer || (r_out_vld && !bus.out_rdy);
    end
  end
endmodule

// File: tb/tb_rr_stream_arb.sv
// tb_rr_stream_arb: directed checks of grant order, burst length, backpressure and reset
module tb_rr_stream_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rr_stream_arb_if #(.NUM_REQ(4), .DATA_W(32)) bus ();
  rr_stream_arb_if #(.NUM_REQ(2), .DATA_W(32)) bus1 ();
  rr_stream_arb #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  rr_stream_arb #(.NUM_REQ(2), .DATA_W(32), .MAX_BURST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          c0;
  logic [3:0]  en;
  logic [31:0] src_q[4][$];
  logic [31:0] log_data[$];
  int          log_src[$];
  int          log_cyc[$];
  int          single_cyc[6] = '{2, 3, 4, 5, 7, 8};
  logic [31:0] sb_data[4] = '{32'hC0, 32'hC1, 32'hB0, 32'hB1};
  int          sb_src[4] = '{3, 3, 0, 0};
  int          sb_cyc[4] = '{2, 3, 6, 7};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    for (int i = 0; i < 4; i++) begin
      bus.req_vld[i] = en[i] && (src_q[i].size() > 0);
      bus.req_data[i*32 +: 32] = (src_q[i].size() > 0) ? src_q[i][0] : 32'h0;
    end
    #1;
    chk("rdy_onehot", 32'($countones(bus.req_rdy) <= 1), 32'd1);
    if (bus.out_vld && bus.out_rdy) begin
      log_data.push_back(bus.out_data);
      log_src.push_back(int'(bus.out_src));
      log_cyc.push_back(cyc);
    end
    for (int i = 0; i < 4; i++)
      if (bus.req_vld[i] && bus.req_rdy[i]) void'(src_q[i].pop_front());
    @(negedge clk);
    cyc++;
  endtask
  task automatic clear_log();
    log_data.delete();
    log_src.delete();
    log_cyc.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    tick();
    rst = 1'b0;
    clear_log();
  endtask
  task automatic run_until(input int n, input int budget);
    for (int t = 0; t < budget && log_data.size() < n; t++) tick();
    chk("beats_within_budget", 32'(log_data.size() >= n), 32'd1);
  endtask
  initial begin
    bus.req_vld = '0;
    bus.req_data = '0;
    bus.out_rdy = 1'b1;
    bus1.req_vld = '0;
    bus1.req_data = '0;
    bus1.out_rdy = 1'b1;
    en = '0;
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_src", 32'(bus.out_src), 32'd0);
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    for (int k = 0; k < 6; k++) src_q[2].push_back(32'hA0 + 32'(k));
    en[2] = 1'b1;
    c0 = cyc;
    run_until(6, 30);
    for (int k = 0; k < 6; k++) begin
      chk("single_data", log_data[k], 32'hA0 + 32'(k));
      chk("single_src", 32'(log_src[k]), 32'd2);
      chk("single_cyc", 32'(log_cyc[k] - c0), 32'(single_cyc[k]));
    end
    repeat (3) tick();
    clear_log();
    src_q[3] = '{32'hC0, 32'hC1};
    src_q[0] = '{32'hB0, 32'hB1};
    en = 4'b1001;
    c0 = cyc;
    run_until(4, 30);
    for (int k = 0; k < 4; k++) begin
      chk("short_data", log_data[k], sb_data[k]);
      chk("short_src", 32'(log_src[k]), 32'(sb_src[k]));
      chk("short_cyc", 32'(log_cyc[k] - c0), 32'(sb_cyc[k]));
    end
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(32'h100 * 32'(i) + 32'(k));
    en = 4'hF;
    c0 = cyc;
    run_until(20, 200);
    for (int j = 0; j < 20; j++) begin
      chk("all_src", 32'(log_src[j]), 32'((j / 4) % 4));
      chk("all_data", log_data[j], 32'h100 * 32'((j / 4) % 4) + 32'((j / 16) * 4 + j % 4));
      chk("all_cyc", 32'(log_cyc[j] - c0), 32'(2 + (j / 4) * 5 + j % 4));
    end
    do_reset();
    for (int k = 0; k < 4; k++) src_q[1].push_back(32'hD0 + 32'(k));
    en[1] = 1'b1;
    repeat (3) tick();
    bus.out_rdy = 1'b0;
    repeat (5) begin
      #1;
      chk("stall_vld", 32'(bus.out_vld), 32'd1);
      chk("stall_data", bus.out_data, 32'hD1);
      chk("stall_src", 32'(bus.out_src), 32'd1);
      chk("stall_req_rdy", 32'(bus.req_rdy), 32'd0);
      tick();
    end
    bus.out_rdy = 1'b1;
    run_until(4, 20);
    repeat (3) tick();
    chk("bp_count", 32'(log_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("bp_data", log_data[k], 32'hD0 + 32'(k));
    do_reset();
    src_q[2] = '{32'hE0};
    en[2] = 1'b1;
    repeat (5) tick();
    for (int k = 0; k < 4; k++) src_q[1].push_back(32'hF0 + 32'(k));
    en[1] = 1'b1;
    repeat (3) tick();
    bus.out_rdy = 1'b0;
    tick();
    #1;
    chk("pre_rst_vld", 32'(bus.out_vld), 32'd1);
    chk("pre_rst_data", bus.out_data, 32'hF1);
    do_reset();
    #1;
    chk("midrst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("midrst_req_rdy", 32'(bus.req_rdy), 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    chk("midrst_out_src", 32'(bus.out_src), 32'd0);
    bus.out_rdy = 1'b1;
    src_q[0] = '{32'h60};
    src_q[3] = '{32'h63};
    en = 4'b1001;
    run_until(1, 20);
    chk("midrst_first_src", 32'(log_src[0]), 32'd0);
    chk("midrst_first_data", log_data[0], 32'h60);
    bus1.req_data = {32'h101, 32'h100};
    bus1.req_vld = 2'b11;
    begin
      int got;
      got = 0;
      for (int t = 0; t < 40 && got < 4; t++) begin
        #1;
        if (bus1.out_vld) begin
          chk("mb1_src", 32'(bus1.out_src), 32'(got % 2));
          chk("mb1_data", bus1.out_data, 32'h100 + 32'(got % 2));
          got++;
        end
        @(negedge clk);
      end
      chk("mb1_beats", 32'(got), 32'd4);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
